// File: rtl/mac_ctrl_pkg.sv
// mac_ctrl_pkg: shared types and default widths for the MAC array sequencer.
//   state_t   - controller FSM states
//   DEF_*     - default lane count, operand/accumulator/length widths, array latency
//   cnt_w()   - width needed to hold values 0..n-1 (at least 1 bit)
package mac_ctrl_pkg;

  localparam int DEF_LANES   = 8;
  localparam int DEF_DW      = 8;
  localparam int DEF_ACC_W   = 16;
  localparam int DEF_LEN_W   = 8;
  localparam int DEF_MAC_LAT = 1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    RESULT
  } state_t;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mac_array_seq_ctrl_if.sv
// mac_array_seq_ctrl_if: operand stream (upstream -> controller) and result
// stream (controller -> downstream), both valid/ready.
//   master - environment side: drives operand beats and result ready
//   slave  - controller side: drives in_ready and the result channel
interface mac_array_seq_ctrl_if
  import mac_ctrl_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int DW    = DEF_DW,
  parameter int ACC_W = DEF_ACC_W
) ();

  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*DW-1:0]    in_a;
  logic [LANES*DW-1:0]    in_b;
  logic                   res_valid;
  logic                   res_ready;
  logic [LANES*ACC_W-1:0] res_data;

  modport master (
    output in_valid, in_a, in_b, res_ready,
    input  in_ready, res_valid, res_data
  );

  modport slave (
    input  in_valid, in_a, in_b, res_ready,
    output in_ready, res_valid, res_data
  );

endinterface

// File: rtl/mac_beat_counter.sv
// mac_beat_counter: loadable down-counter.
//   clk, rst  - clock, asynchronous active-high reset (count -> 0)
//   load      - load load_val (wins over dec)
//   dec       - decrement by one; holds at zero
//   count     - current value
//   zero      - count == 0
module mac_beat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     count <= '0;
    else if (load)               count <= load_val;
    else if (dec && count != '0) count <= count - W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mac_array_seq_ctrl.sv
// mac_array_seq_ctrl: sequencer for the MAC lane array.
// Takes a job length on start, clears the accumulators, streams len operand
// beats into the array, waits out the array latency, captures all lane
// accumulators and offers them downstream.
//   clk, rst       - clock, asynchronous active-high reset
//   start, len     - job request (sampled only in IDLE) and beat count
//   abort          - cancel current job / drop pending result
//   busy           - any state other than IDLE
//   bus (slave)    - operand stream in, result stream out
//   mac_clr/mac_en - accumulator clear / accumulate enable to the array
//   mac_a, mac_b   - registered lane operands to the array
//   mac_out        - lane accumulators from the array
module mac_array_seq_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int LANES   = DEF_LANES,
  parameter int DW      = DEF_DW,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int MAC_LAT = DEF_MAC_LAT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [LEN_W-1:0]       len,
  input  logic                   abort,
  output logic                   busy,
  mac_array_seq_ctrl_if.slave    bus,
  output logic                   mac_clr,
  output logic                   mac_en,
  output logic [LANES*DW-1:0]    mac_a,
  output logic [LANES*DW-1:0]    mac_b,
  input  logic [LANES*ACC_W-1:0] mac_out
);

  // Drain counter runs MAC_LAT..0, i.e. MAC_LAT+1 DRAIN cycles.
  localparam int DRN_W = cnt_w(MAC_LAT + 1);

  state_t state, state_n;

  logic                   accept;
  logic                   beat_load, drain_load, capture;
  logic [LEN_W-1:0]       beat_cnt;
  logic                   beat_zero;
  logic [DRN_W-1:0]       drain_cnt_unused;
  logic                   drain_zero;
  logic [LANES*ACC_W-1:0] res_q;

  // Abort masks ready so a cancelled job never consumes the beat on offer.
  assign bus.in_ready  = (state == STREAM) && !abort;
  assign accept        = bus.in_ready && bus.in_valid;
  assign bus.res_valid = (state == RESULT);
  assign bus.res_data  = res_q;
  assign busy          = (state != IDLE);
  assign mac_clr       = (state == CLEAR);

  mac_beat_counter #(.W(LEN_W)) u_beat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (beat_load),
    .load_val (len),
    .dec      (accept),
    .count    (beat_cnt),
    .zero     (beat_zero)
  );

  mac_beat_counter #(.W(DRN_W)) u_drain_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (drain_load),
    .load_val (DRN_W'(MAC_LAT)),
    .dec      (state == DRAIN),
    .count    (drain_cnt_unused),
    .zero     (drain_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    beat_load  = 1'b0;
    drain_load = 1'b0;
    capture    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          beat_load = 1'b1;
          state_n   = CLEAR;
        end
      end
      CLEAR: begin
        if (abort) state_n = IDLE;
        else if (beat_zero) begin
          // Empty job: skip streaming, result is the cleared accumulators.
          drain_load = 1'b1;
          state_n    = DRAIN;
        end else state_n = STREAM;
      end
      STREAM: begin
        if (abort) state_n = IDLE;
        else if (accept && beat_cnt == LEN_W'(1)) begin
          drain_load = 1'b1;
          state_n    = DRAIN;
        end
      end
      DRAIN: begin
        if (abort) state_n = IDLE;
        else if (drain_zero) begin
          capture = 1'b1;
          state_n = RESULT;
        end
      end
      RESULT: begin
        if (abort || bus.res_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Operands are registered on acceptance; mac_en marks the cycle they are
  // valid at the array, so it trails each accepted beat by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mac_en <= 1'b0;
      mac_a  <= '0;
      mac_b  <= '0;
    end else begin
      mac_en <= accept;
      if (accept) begin
        mac_a <= bus.in_a;
        mac_b <= bus.in_b;
      end
    end
  end

  // Result holds across the handshake until the next job captures.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          res_q <= '0;
    else if (capture) res_q <= mac_out;
  end

endmodule

// File: tb/tb_mac_array_seq_ctrl.sv
module tb_mac_array_seq_ctrl;
  import mac_ctrl_pkg::*;

  localparam int LANES   = DEF_LANES;
  localparam int DW      = DEF_DW;
  localparam int ACC_W   = DEF_ACC_W;
  localparam int LEN_W   = DEF_LEN_W;
  localparam int MAC_LAT = DEF_MAC_LAT;
  localparam int AW      = LANES * DW;
  localparam int RW      = LANES * ACC_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             busy, mac_clr, mac_en;
  logic [AW-1:0]    mac_a, mac_b;
  logic [RW-1:0]    mac_out;

  int checks = 0;
  int errors = 0;

  int   cyc = 0;
  int   n_en = 0;
  int   n_clr = 0;
  int   en_err = 0;
  logic acc_edge = 1'b0;

  logic [AW-1:0] qa[$];
  logic [AW-1:0] qb[$];
  logic [RW-1:0] last_exp = '0;

  mac_array_seq_ctrl_if #(.LANES(LANES), .DW(DW), .ACC_W(ACC_W)) bus ();

  mac_array_seq_ctrl #(
    .LANES(LANES), .DW(DW), .ACC_W(ACC_W), .LEN_W(LEN_W), .MAC_LAT(MAC_LAT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .len     (len),
    .abort   (abort),
    .busy    (busy),
    .bus     (bus.slave),
    .mac_clr (mac_clr),
    .mac_en  (mac_en),
    .mac_a   (mac_a),
    .mac_b   (mac_b),
    .mac_out (mac_out)
  );

  always #5 clk = ~clk;

  // Array stand-in: one-cycle MAC per lane, never reset.
  logic [LANES-1:0][ACC_W-1:0] arr = '0;
  always @(posedge clk) begin
    if (mac_clr) arr <= '0;
    else if (mac_en)
      for (int l = 0; l < LANES; l++)
        arr[l] <= arr[l] + ACC_W'(32'(mac_a[l*DW +: DW]) * 32'(mac_b[l*DW +: DW]));
  end
  assign mac_out = arr;

  // Protocol monitor: mac_en must be high exactly in the cycle after a handshake.
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    acc_edge <= bus.in_valid && bus.in_ready;
  end
  always @(negedge clk) begin
    if (!rst) begin
      if (mac_en) n_en <= n_en + 1;
      if (mac_clr) n_clr <= n_clr + 1;
      if (mac_en !== acc_edge) en_err <= en_err + 1;
    end
  end

  // Reference: per lane, sum of a*b over the job's beats, modulo 2^ACC_W.
  function automatic logic [RW-1:0] model_result();
    logic [RW-1:0] r;
    logic [AW-1:0] ta, tb;
    int s;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      s = 0;
      for (int k = 0; k < qa.size(); k++) begin
        ta = qa[k];
        tb = qb[k];
        s += int'(ta[l*DW +: DW]) * int'(tb[l*DW +: DW]);
      end
      r[l*ACC_W +: ACC_W] = ACC_W'(s % (1 << ACC_W));
    end
    return r;
  endfunction

  function automatic logic [AW-1:0] rvec();
    logic [AW-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_job(input int n);
    start = 1'b1;
    len   = LEN_W'(n);
    tick();
    start = 1'b0;
  endtask

  // Offer one beat after `gap` idle cycles; acc_cyc = edge index of the handshake.
  task automatic send_beat(input logic [AW-1:0] a, input logic [AW-1:0] b,
                           input int gap, output int acc_cyc);
    repeat (gap) tick();
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    acc_cyc      = -1;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (bus.in_ready) begin
        tick();
        acc_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    qa.push_back(a);
    qb.push_back(b);
    if (acc_cyc < 0) begin
      checks++; errors++;
      $display("FAIL beat_timeout: in_ready never seen within 200 cycles");
    end
  endtask

  task automatic wait_result(output int seen);
    seen = -1;
    for (int i = 0; i < 50; i++) begin
      if (bus.res_valid) begin
        seen = cyc;
        return;
      end
      tick();
    end
    checks++; errors++;
    $display("FAIL result_timeout: res_valid never seen within 50 cycles");
  endtask

  task automatic take_result();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    checks++; if (mac_clr !== 1'b0 || mac_en !== 1'b0) begin errors++; $display("FAIL reset_mac_ctl: got clr=%b en=%b want 0/0", mac_clr, mac_en); end
    checks++; if (mac_a !== '0 || mac_b !== '0) begin errors++; $display("FAIL reset_mac_ops: got a=%h b=%h want 0", mac_a, mac_b); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", bus.res_valid); end
    checks++; if (bus.res_data !== '0) begin errors++; $display("FAIL reset_res_data: got %h want 0", bus.res_data); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_beat();
    logic [AW-1:0] a, b;
    logic [RW-1:0] exp;
    int p, seen, e0, c0, er0;
    a = {8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
    b = {8'd10, 8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3};
    qa.delete(); qb.delete();
    e0 = n_en; c0 = n_clr; er0 = en_err;
    start_job(1);
    checks++; if (mac_clr !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_clear: got clr=%b busy=%b want 1/1", mac_clr, busy); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL single_clear_ready: got %b want 0", bus.in_ready); end
    tick();
    checks++; if (mac_clr !== 1'b0) begin errors++; $display("FAIL single_clr_len: got %b want 0 after one cycle", mac_clr); end
    send_beat(a, b, 0, p);
    checks++; if (mac_en !== 1'b1) begin errors++; $display("FAIL single_mac_en: got %b want 1", mac_en); end
    checks++; if (mac_a !== a || mac_b !== b) begin errors++; $display("FAIL single_ops: got a=%h b=%h want a=%h b=%h", mac_a, mac_b, a, b); end
    exp = model_result();
    wait_result(seen);
    checks++; if (seen != p + MAC_LAT + 1) begin errors++; $display("FAIL single_latency: got edge %0d want %0d", seen, p + MAC_LAT + 1); end
    checks++; if (bus.res_data !== exp) begin errors++; $display("FAIL single_data: got %h want %h", bus.res_data, exp); end
    checks++; if (n_en - e0 != 1 || n_clr - c0 != 1) begin errors++; $display("FAIL single_pulses: got en=%0d clr=%0d want 1/1", n_en - e0, n_clr - c0); end
    take_result();
    last_exp = exp;
    checks++; if (bus.res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_handshake: got valid=%b busy=%b want 0/0", bus.res_valid, busy); end
    checks++; if (bus.res_data !== exp) begin errors++; $display("FAIL single_hold: got %h want %h", bus.res_data, exp); end
    checks++; if (en_err != er0) begin errors++; $display("FAIL single_en_align: got %0d misaligned mac_en want 0", en_err - er0); end
  endtask

  task automatic test_gaps();
    logic [AW-1:0] a, b;
    logic [RW-1:0] exp;
    int p, seen, e0, er0;
    a = {8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
    b = {8'd10, 8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3};
    qa.delete(); qb.delete();
    e0 = n_en; er0 = en_err;
    start_job(3);
    tick();
    send_beat(a, b, 0, p);
    send_beat(a, b, 2, p);
    send_beat(a, b, 1, p);
    exp = model_result();
    wait_result(seen);
    checks++; if (seen != p + MAC_LAT + 1) begin errors++; $display("FAIL gaps_latency: got edge %0d want %0d", seen, p + MAC_LAT + 1); end
    checks++; if (bus.res_data !== exp) begin errors++; $display("FAIL gaps_data: got %h want %h", bus.res_data, exp); end
    checks++; if (n_en - e0 != 3) begin errors++; $display("FAIL gaps_en_count: got %0d want 3", n_en - e0); end
    checks++; if (en_err != er0) begin errors++; $display("FAIL gaps_en_align: got %0d misaligned mac_en want 0", en_err - er0); end
    take_result();
    last_exp = exp;
  endtask

  task automatic test_wrap_backpressure();
    logic [AW-1:0] a;
    logic [RW-1:0] exp;
    int p, seen;
    a = '1;
    qa.delete(); qb.delete();
    start_job(2);
    tick();
    send_beat(a, a, 0, p);
    send_beat(a, a, 0, p);
    exp = model_result();
    wait_result(seen);
    checks++; if (bus.res_data !== exp) begin errors++; $display("FAIL wrap_data: got %h want %h", bus.res_data, exp); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus.res_valid !== 1'b1 || busy !== 1'b1 || bus.res_data !== exp) begin
        errors++; $display("FAIL wrap_stall: cycle %0d got valid=%b busy=%b data=%h want 1/1/%h", i, bus.res_valid, busy, bus.res_data, exp);
      end
    end
    take_result();
    last_exp = exp;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrap_release: got busy=%b want 0", busy); end
  endtask

  task automatic test_len0_ignored_start();
    logic [RW-1:0] exp;
    int c, p, seen, e0;
    qa.delete(); qb.delete();
    e0 = n_en;
    start_job(0);
    c = cyc;
    checks++; if (mac_clr !== 1'b1) begin errors++; $display("FAIL len0_clear: got %b want 1", mac_clr); end
    tick();
    checks++; if (busy !== 1'b1 || bus.in_ready !== 1'b0 || mac_clr !== 1'b0) begin errors++; $display("FAIL len0_drain: got busy=%b ready=%b clr=%b want 1/0/0", busy, bus.in_ready, mac_clr); end
    exp = model_result();
    wait_result(seen);
    checks++; if (seen != c + MAC_LAT + 2) begin errors++; $display("FAIL len0_latency: got edge %0d want %0d", seen, c + MAC_LAT + 2); end
    checks++; if (bus.res_data !== exp) begin errors++; $display("FAIL len0_data: got %h want %h", bus.res_data, exp); end
    checks++; if (n_en != e0) begin errors++; $display("FAIL len0_no_en: got %0d pulses want 0", n_en - e0); end
    take_result();
    last_exp = exp;

    qa.delete(); qb.delete();
    e0 = n_en;
    start_job(4);
    tick();
    send_beat(rvec(), rvec(), 0, p);
    start = 1'b1; len = LEN_W'(7);
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) send_beat(rvec(), rvec(), $urandom_range(0, 2), p);
    exp = model_result();
    wait_result(seen);
    checks++; if (seen != p + MAC_LAT + 1) begin errors++; $display("FAIL ign_latency: got edge %0d want %0d", seen, p + MAC_LAT + 1); end
    checks++; if (bus.res_data !== exp) begin errors++; $display("FAIL ign_data: got %h want %h", bus.res_data, exp); end
    checks++; if (n_en - e0 != 4) begin errors++; $display("FAIL ign_en_count: got %0d want 4", n_en - e0); end
    start = 1'b1; len = LEN_W'(9);
    tick();
    start = 1'b0;
    checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== exp) begin errors++; $display("FAIL ign_result_start: got valid=%b data=%h want 1/%h", bus.res_valid, bus.res_data, exp); end
    take_result();
    last_exp = exp;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_no_pending: got busy=%b want 0", busy); end
  endtask

  task automatic test_abort();
    logic [AW-1:0] a2;
    logic [RW-1:0] exp;
    int p, seen;
    // abort mid-STREAM while a beat is offered
    qa.delete(); qb.delete();
    start_job(4);
    tick();
    send_beat(rvec(), rvec(), 0, p);
    a2 = rvec();
    send_beat(a2, rvec(), 0, p);
    abort = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_a = rvec();
    bus.in_b = rvec();
    tick();
    abort = 1'b0;
    bus.in_valid = 1'b0;
    checks++; if (busy !== 1'b0 || bus.res_valid !== 1'b0) begin errors++; $display("FAIL abort_stream_idle: got busy=%b valid=%b want 0/0", busy, bus.res_valid); end
    checks++; if (mac_en !== 1'b0 || mac_a !== a2) begin errors++; $display("FAIL abort_stream_beat: got en=%b a=%h want 0/%h", mac_en, mac_a, a2); end
    repeat (3) tick();
    checks++; if (bus.res_valid !== 1'b0 || bus.res_data !== last_exp) begin errors++; $display("FAIL abort_stream_nocap: got valid=%b data=%h want 0/%h", bus.res_valid, bus.res_data, last_exp); end

    // next job must start from cleared accumulators
    qa.delete(); qb.delete();
    start_job(1);
    tick();
    send_beat(rvec(), rvec(), 0, p);
    exp = model_result();
    wait_result(seen);
    checks++; if (bus.res_data !== exp) begin errors++; $display("FAIL abort_next_data: got %h want %h", bus.res_data, exp); end
    take_result();
    last_exp = exp;

    // abort in DRAIN: no capture
    qa.delete(); qb.delete();
    start_job(1);
    tick();
    send_beat(rvec(), rvec(), 0, p);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_drain_idle: got busy=%b want 0", busy); end
    repeat (3) tick();
    checks++; if (bus.res_valid !== 1'b0 || bus.res_data !== last_exp) begin errors++; $display("FAIL abort_drain_nocap: got valid=%b data=%h want 0/%h", bus.res_valid, bus.res_data, last_exp); end

    // abort in RESULT drops the result
    qa.delete(); qb.delete();
    start_job(1);
    tick();
    send_beat(rvec(), rvec(), 0, p);
    exp = model_result();
    wait_result(seen);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    last_exp = exp;
    checks++; if (bus.res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_result: got valid=%b busy=%b want 0/0", bus.res_valid, busy); end
    checks++; if (bus.res_data !== exp) begin errors++; $display("FAIL abort_result_hold: got %h want %h", bus.res_data, exp); end
  endtask

  task automatic test_async_reset();
    logic [RW-1:0] exp;
    int p, seen;
    qa.delete(); qb.delete();
    start_job(5);
    tick();
    send_beat(rvec() | AW'(1), rvec() | AW'(1), 0, p);
    send_beat(rvec() | AW'(1), rvec() | AW'(1), 0, p);
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.res_valid !== 1'b0) begin errors++; $display("FAIL arst_ctl: got busy=%b ready=%b valid=%b want 0/0/0", busy, bus.in_ready, bus.res_valid); end
    checks++; if (mac_clr !== 1'b0 || mac_en !== 1'b0 || mac_a !== '0 || mac_b !== '0) begin errors++; $display("FAIL arst_mac: got clr=%b en=%b a=%h b=%h want all 0", mac_clr, mac_en, mac_a, mac_b); end
    checks++; if (bus.res_data !== '0) begin errors++; $display("FAIL arst_res_data: got %h want 0", bus.res_data); end
    last_exp = '0;
    @(negedge clk);
    rst = 1'b0;
    qa.delete(); qb.delete();
    start_job(2);
    checks++; if (mac_clr !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL arst_restart: got clr=%b busy=%b want 1/1", mac_clr, busy); end
    tick();
    send_beat(rvec(), rvec(), 0, p);
    send_beat(rvec(), rvec(), 1, p);
    exp = model_result();
    wait_result(seen);
    checks++; if (bus.res_data !== exp) begin errors++; $display("FAIL arst_next_data: got %h want %h", bus.res_data, exp); end
    take_result();
    last_exp = exp;
  endtask

  task automatic test_back_to_back();
    logic [RW-1:0] exp;
    int n, p, seen, e0;
    for (int j = 0; j < 7; j++) begin
      n = (j == 6) ? 255 : $urandom_range(1, 6);
      qa.delete(); qb.delete();
      e0 = n_en;
      start_job(n);
      for (int k = 0; k < n; k++) send_beat(rvec(), rvec(), (j == 6) ? 0 : $urandom_range(0, 2), p);
      exp = model_result();
      wait_result(seen);
      checks++; if (seen != p + MAC_LAT + 1) begin errors++; $display("FAIL b2b_latency: job %0d got edge %0d want %0d", j, seen, p + MAC_LAT + 1); end
      checks++; if (bus.res_data !== exp) begin errors++; $display("FAIL b2b_data: job %0d len %0d got %h want %h", j, n, bus.res_data, exp); end
      checks++; if (n_en - e0 != n) begin errors++; $display("FAIL b2b_en_count: job %0d got %0d want %0d", j, n_en - e0, n); end
      repeat ($urandom_range(0, 3)) tick();
      take_result();
      last_exp = exp;
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.res_ready = 1'b0;
    test_reset();
    test_single_beat();
    test_gaps();
    test_wrap_backpressure();
    test_len0_ignored_start();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/mac_array_seq_ctrl.md
Name: mac_array_seq_ctrl

Overview:
- Sequencer for the 8-lane MAC array.
- Accepts a job length, then streams operand beats from an upstream valid/ready source into the array.
- Clears the accumulators before the first beat and waits out the array latency.
- Captures all lane accumulators into a result register and presents them to a downstream valid/ready consumer.

Parameters:
LANES, 8, number of MAC lanes
DW, 8, operand width per lane (unsigned)
ACC_W, 16, accumulator width per lane
LEN_W, 8, width of job length (max 255 beats)
MAC_LAT, 1, cycles from a mac_en cycle until mac_out reflects it

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  job request pulse; sampled only in IDLE
len  in  LEN_W  number of operand beats for the job
abort  in  1  synchronous job cancel
busy  out  1  high in every state except IDLE
in_valid  in  1  operand beat valid
in_ready  out  1  operand beat accepted when in_valid && in_ready
in_a  in  LANES*DW  lane operands A; lane i = bits [i*DW +: DW]
in_b  in  LANES*DW  lane operands B
mac_clr  out  1  synchronous accumulator clear to the array
mac_en  out  1  accumulate enable to the array
mac_a  out  LANES*DW  registered operands A to the array
mac_b  out  LANES*DW  registered operands B to the array
mac_out  in  LANES*ACC_W  lane accumulators from the array
res_valid  out  1  result available
res_ready  in  1  result consumed when res_valid && res_ready
res_data  out  LANES*ACC_W  captured accumulators

Behaviour:
- Reset: the state is IDLE. All outputs are 0: busy, in_ready, mac_clr, mac_en, mac_a, mac_b, res_valid, res_data. Reset mid-job discards the job. The array's accumulators are not cleared by reset; the next job's CLEAR clears them.
- States: IDLE, CLEAR, STREAM, DRAIN, RESULT.
- IDLE:
  - On start, latch len into the remaining-beat counter and go to CLEAR.
  - start in any other state is ignored.
- CLEAR:
  - Lasts exactly 1 cycle with mac_clr=1.
  - Goes to STREAM if the latched len != 0, otherwise to DRAIN.
  - A job with len=0 yields an all-zero result.
- STREAM:
  - in_ready=1 combinationally.
  - On each accepted beat, register in_a/in_b into mac_a/mac_b and set mac_en=1 for the next cycle. mac_en is 0 in any cycle following a non-accepted cycle.
  - Decrement the counter on each accepted beat; on the beat that takes it to 0, go to DRAIN.
  - Gaps in in_valid are allowed and stall the job without limit.
- DRAIN:
  - Lasts exactly MAC_LAT+1 cycles, counted by a drain counter.
  - The first DRAIN cycle may carry mac_en=1 for the last beat.
  - On the final DRAIN edge, sample mac_out into res_data and go to RESULT.
- RESULT:
  - res_valid=1; res_data is held stable until the handshake.
  - On res_valid && res_ready, go to IDLE and drop res_valid the next cycle.
  - res_data retains its value after the handshake, until the next capture.
- mac_a/mac_b hold their last values when mac_en=0.
- Latency: last beat accepted at edge T gives res_valid high after edge T+MAC_LAT+1.
- abort:
  - In CLEAR, STREAM or DRAIN, abort goes to IDLE next cycle. mac_en is forced 0 the next cycle, no capture occurs, and res_data is unchanged.
  - In RESULT, abort goes to IDLE and drops res_valid.
  - In IDLE, abort has no effect.
  - abort has priority over a simultaneous beat acceptance or result handshake.
- Arithmetic: the controller performs no arithmetic on data. Accumulation wraps modulo 2^ACC_W in the array; res_data reflects the wrapped value.

Decomposition:
- Shared package mac_ctrl_pkg holds:
  - the state enum (IDLE, CLEAR, STREAM, DRAIN, RESULT)
  - default widths LANES, DW, ACC_W, LEN_W
  - MAC_LAT default
- Sub-module mac_beat_counter: a loadable down-counter with load, dec and zero flag. It is instantiated twice, once for remaining beats (LEN_W) and once for drain cycles.
- The FSM and the operand/result registers stay in the top module.

Test Plan:
- Single beat: len=1, a={80,70,60,50,40,30,20,10} (lane7..0), b={10,9,8,7,6,5,4,3} -> res_data lanes0..7 = 30,80,150,240,350,480,630,800; mac_clr one cycle before first mac_en; res_valid 2 cycles after acceptance.
- Three beats with in_valid gaps (valid 1,0,0,1,0,1), same vectors -> result lanes = 90,240,450,720,1050,1440,1890,2400; mac_en pulses exactly 3 times, each one cycle after an acceptance.
- Wrap and back-pressure: len=2, all a=255, b=255 -> every lane 64514. res_ready low for 5 cycles -> res_valid and res_data stable; busy=1 until the handshake.
- len=0 -> CLEAR, DRAIN, RESULT with res_data all 0 and no mac_en. Then start while busy on a len=4 job -> ignored, and the job completes after exactly 4 beats.
- abort after 2 of 4 beats -> IDLE next cycle, no res_valid, res_data unchanged. A following len=1 job produces a correct (cleared) result.
- Async rst asserted mid-STREAM, off-clock-edge -> all outputs 0 immediately, state IDLE. After release, start is accepted on the next cycle.
